data_cache_ctrl: RTL
====================

// Module: data_cache_ctrl
// PURPOSE
//  Direct-mapped, write-back data cache between CPU load/store path and word-wide data memory.
//  Load data feeds reg_file IN; BUSYWAIT stalls PC and reg_file writes during misses.
//  Lines: 8 blocks x 4 bytes; 8-bit byte address = tag[7:5] | index[4:2] | offset[1:0].
// PARAMETERS
//  NUM_BLOCKS   8   cache lines (power of two; index width = log2)
//  BLOCK_BYTES  4   bytes per line (fixed: memory word is 32 bits)
//  ADDR_W       8   CPU byte-address width
// PORTS
//  CLK            in   1   clock, all state updates on posedge
//  RESET          in   1   reset RESET, synchronous, active-low; clock CLK
//  READ           in   1   CPU load request (level, held until BUSYWAIT low)
//  WRITE          in   1   CPU store request (level, held until BUSYWAIT low)
//  ADDRESS        in   8   CPU byte address
//  WRITEDATA      in   8   store data
//  READDATA       out  8   load data (combinational on hit)
//  BUSYWAIT       out  1   stall CPU while request unresolved
//  MEM_READ       out  1   memory block read request
//  MEM_WRITE      out  1   memory block write-back request
//  MEM_ADDRESS    out  6   block address {tag,index}
//  MEM_WRITEDATA  out  32  victim block, byte0 in [7:0]
//  MEM_READDATA   in   32  fetched block, byte0 in [7:0]
//  MEM_BUSYWAIT   in   1   memory busy; transfer done on first cycle sampled low
// BEHAVIOUR
//  - Reset (RESET=0 at posedge): all valid/dirty bits 0, state IDLE; next cycle BUSYWAIT=0,
//    MEM_READ=MEM_WRITE=0, READDATA=0. Data/tag arrays not cleared. Overrides any state.
//  - Reset mid-miss aborts: memory requests drop next cycle; dirty victim data is lost.
//  - hit = valid[index] && tag[index]==ADDRESS[7:5]. READ&WRITE both high: treated as WRITE.
//  - IDLE, no request: BUSYWAIT=0.
//  - Read hit: READDATA=data[index][offset] same cycle, BUSYWAIT=0, zero stall.
//  - Write hit: BUSYWAIT=0; byte written and dirty set at next posedge.
//  - Miss: BUSYWAIT=1 combinationally in IDLE; state advances at next posedge:
//      clean/invalid victim -> MEM_READ; dirty victim -> MEM_WRITE.
//  - MEM_WRITE: MEM_WRITE=1, MEM_ADDRESS={old tag,index}, MEM_WRITEDATA=victim;
//      MEM_BUSYWAIT low at posedge -> MEM_READ.
//  - MEM_READ: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2]; MEM_BUSYWAIT low -> UPDATE.
//  - UPDATE (1 cycle): line <= MEM_READDATA, tag set, valid=1, dirty=0; BUSYWAIT=1; -> IDLE.
//  - Back in IDLE the held request now hits and completes as above (miss cost >= 3 cycles).
//  - MEM_READ and MEM_WRITE never high together; both 0 outside their states.
//  - Request dropped while not IDLE: fill still completes, no CPU-visible effect.
// CONFIGURATION
//  - DCACHE_STATS_EN defined: adds outputs HIT_COUNT[15:0], MISS_COUNT[15:0]; one count per
//    completed access (hit in IDLE) or per miss entry (IDLE->fill); wrap at 16'hFFFF->0;
//    cleared by RESET. Refill-completion hit is not counted as a hit.
//  - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package dcache_pkg: state enum {IDLE,MEM_WRITE,MEM_READ,UPDATE}, TAG_W=3, IDX_W=3,
//    OFF_W=2, address field slice localparams.
//  - Sub-module dcache_tag_array: valid/dirty/tag storage + hit/dirty compare, sync reset.
//  - Top holds data array, FSM, memory interface mux, optional stats counters.
// TESTING
//  1 Reset then READ 0x00 -> BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=6'h00; mem returns
//    32'h44332211 -> after UPDATE READDATA=8'h11, BUSYWAIT=0.
//  2 Read hit: READ 0x03 after test 1 -> READDATA=8'h44 same cycle, no MEM_READ.
//  3 Write hit WRITE 0x01 data 8'hAA -> BUSYWAIT=0; later READ 0x01 -> 8'hAA.
//  4 Dirty evict: WRITE to 0x20 (same index 0, tag 1) -> MEM_WRITE=1, MEM_ADDRESS=6'h00,
//    MEM_WRITEDATA=32'h4433AA11; then MEM_READ with MEM_ADDRESS=6'h08.
//  5 RESET low during MEM_READ wait -> next cycle MEM_READ=0, BUSYWAIT=0; READ 0x00 misses.
//  6 DCACHE_STATS_EN: tests 1-3 -> HIT_COUNT=3, MISS_COUNT=1; reset -> both 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address field layout for the direct-mapped data cache.
package dcache_pkg;
    localparam int NUM_BLOCKS  = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int ADDR_W      = 8;
    localparam int TAG_W       = 3;
    localparam int IDX_W       = 3;
    localparam int OFF_W       = 2;
    localparam int OFF_LSB     = 0;
    localparam int IDX_LSB     = OFF_LSB + OFF_W;
    localparam int TAG_LSB     = IDX_LSB + IDX_W;
    localparam int LINE_W      = BLOCK_BYTES * 8;

    typedef enum logic [1:0] {IDLE, MEM_WRITE, MEM_READ, UPDATE} dc_state_t;
endpackage

// File: rtl/dcache_tag_array.sv
// Valid/dirty/tag storage with hit and victim-dirty lookup for the current index.
module dcache_tag_array
    import dcache_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic [IDX_W-1:0] index,
    input  logic [TAG_W-1:0] tag,
    input  logic             fill,
    input  logic             set_dirty,
    output logic             hit,
    output logic             victim_dirty,
    output logic [TAG_W-1:0] victim_tag
);
    logic [NUM_BLOCKS-1:0] valid;
    logic [NUM_BLOCKS-1:0] dirty;
    logic [TAG_W-1:0]      tags [NUM_BLOCKS];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (set_dirty) begin
            dirty[index] <= 1'b1;
        end
    end

    // Tags are not cleared by reset; valid gates their use.
    always_ff @(posedge CLK) begin
        if (RESET && fill)
            tags[index] <= tag;
    end

    assign victim_tag   = tags[index];
    assign hit          = valid[index] && (tags[index] == tag);
    assign victim_dirty = valid[index] && dirty[index];
endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-back data cache controller between CPU and word-wide memory.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
//
// state     | meaning
// IDLE      | serve hits, detect misses
// MEM_WRITE | write dirty victim block back to memory
// MEM_READ  | fetch requested block from memory
// UPDATE    | install fetched block, clear dirty, return to IDLE
module data_cache_ctrl (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              READ,
    input  logic                              WRITE,
    input  logic [dcache_pkg::ADDR_W-1:0]     ADDRESS,
    input  logic [7:0]                        WRITEDATA,
    output logic [7:0]                        READDATA,
    output logic                              BUSYWAIT,
    output logic                              MEM_READ,
    output logic                              MEM_WRITE,
    output logic [dcache_pkg::TAG_W+dcache_pkg::IDX_W-1:0] MEM_ADDRESS,
    output logic [dcache_pkg::LINE_W-1:0]     MEM_WRITEDATA,
    input  logic [dcache_pkg::LINE_W-1:0]     MEM_READDATA,
    input  logic                              MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]                       HIT_COUNT,
    output logic [15:0]                       MISS_COUNT
`endif
);
    localparam int TAG_W      = dcache_pkg::TAG_W;
    localparam int IDX_W      = dcache_pkg::IDX_W;
    localparam int OFF_W      = dcache_pkg::OFF_W;
    localparam int LINE_W     = dcache_pkg::LINE_W;
    localparam int NUM_BLOCKS = dcache_pkg::NUM_BLOCKS;

    dcache_pkg::dc_state_t state, next_state;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic              req, hit, victim_dirty;
    logic [TAG_W-1:0]  victim_tag;
    logic              fill, wr_hit, rd_hit, miss_start;
    logic [LINE_W-1:0] data_mem [NUM_BLOCKS];

    assign tag = ADDRESS[dcache_pkg::TAG_LSB +: TAG_W];
    assign idx = ADDRESS[dcache_pkg::IDX_LSB +: IDX_W];
    assign off = ADDRESS[dcache_pkg::OFF_LSB +: OFF_W];
    assign req = READ || WRITE;

    dcache_tag_array u_tags (
        .CLK          (CLK),
        .RESET        (RESET),
        .index        (idx),
        .tag          (tag),
        .fill         (fill),
        .set_dirty    (wr_hit),
        .hit          (hit),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag)
    );

    always_ff @(posedge CLK) begin
        if (!RESET)
            state <= dcache_pkg::IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state  = state;
        BUSYWAIT    = 1'b0;
        MEM_READ    = 1'b0;
        MEM_WRITE   = 1'b0;
        MEM_ADDRESS = {tag, idx};
        fill        = 1'b0;
        wr_hit      = 1'b0;
        rd_hit      = 1'b0;
        miss_start  = 1'b0;
        case (state)
            dcache_pkg::IDLE: begin
                if (req) begin
                    if (hit) begin
                        wr_hit = WRITE;
                        rd_hit = !WRITE;
                    end else begin
                        BUSYWAIT   = 1'b1;
                        miss_start = 1'b1;
                        next_state = victim_dirty ? dcache_pkg::MEM_WRITE : dcache_pkg::MEM_READ;
                    end
                end
            end
            dcache_pkg::MEM_WRITE: begin
                BUSYWAIT    = 1'b1;
                MEM_WRITE   = 1'b1;
                MEM_ADDRESS = {victim_tag, idx};
                if (!MEM_BUSYWAIT)
                    next_state = dcache_pkg::MEM_READ;
            end
            dcache_pkg::MEM_READ: begin
                BUSYWAIT = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT)
                    next_state = dcache_pkg::UPDATE;
            end
            dcache_pkg::UPDATE: begin
                BUSYWAIT   = 1'b1;
                fill       = 1'b1;
                next_state = dcache_pkg::IDLE;
            end
            default: next_state = dcache_pkg::IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (fill)
                data_mem[idx] <= MEM_READDATA;
            else if (wr_hit)
                data_mem[idx][{off, 3'b000} +: 8] <= WRITEDATA;
        end
    end

    assign MEM_WRITEDATA = data_mem[idx];
    assign READDATA      = rd_hit ? data_mem[idx][{off, 3'b000} +: 8] : 8'h00;

`ifdef DCACHE_STATS_EN
    // The first hit after a refill belongs to the miss just serviced.
    logic refill_hit;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
            refill_hit <= 1'b0;
        end else begin
            refill_hit <= (state == dcache_pkg::UPDATE) && req;
            if ((wr_hit || rd_hit) && !refill_hit)
                HIT_COUNT <= HIT_COUNT + 16'd1;
            if (miss_start)
                MISS_COUNT <= MISS_COUNT + 16'd1;
        end
    end
`endif
endmodule
